dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the datapath memory port (Address/WriteData/ReadData) and a slow backing data memory with a req/ack handshake.
- Stalls the core on read misses and on every write.
- Keeps saturating hit/miss counters for performance inspection.

Parameters:
NBITS, 8, data word width; CPU word address is Address[NBITS-1:2].
NLINES, 4, number of cache lines (one word per line, power of two, >=2).
CNTW, 8, width of the hit/miss counters.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
Address  in  NBITS-2  word address from datapath (bits NBITS-1:2)
WriteData  in  NBITS  store data from datapath
MemRead  in  1  load request
MemWrite  in  1  store request
ReadData  out  NBITS  load data to datapath
Stall  out  1  core must hold request and PC while high
mem_req  out  1  backing memory request
mem_we  out  1  1=write, 0=read, valid with mem_req
mem_addr  out  NBITS-2  backing word address
mem_wdata  out  NBITS  backing write data
mem_rdata  in  NBITS  backing read data, valid when mem_ack=1
mem_ack  in  1  one-cycle completion pulse from backing memory
hit_count  out  CNTW  saturating read-hit counter
miss_count  out  CNTW  saturating read-miss counter

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clock and reset.
- Reset values:
  - All valid bits 0; state IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - hit_count=0, miss_count=0.
  - Stall=0 and ReadData=0 when no request is present.
- Address split:
  - index = Address[log2(NLINES)-1:0].
  - tag = remaining upper bits.
  - hit = valid[index] && tag_mem[index]==tag.
- MemRead and MemWrite both high: treated as a write; MemRead is ignored.
- IDLE state:
  - No request: Stall=0, ReadData=0.
  - MemRead and hit: ReadData=data[index] combinationally, Stall=0, hit_count+1 (saturating at all-ones). Stays in IDLE.
  - MemRead and miss: Stall=1 combinationally, miss_count+1 (saturating), latch addr. Go to FILL.
  - MemWrite: Stall=1 combinationally, latch addr and WriteData. Go to WRITE.
- FILL state:
  - mem_req=1, mem_we=0, mem_addr=latched addr, Stall=1.
  - On mem_ack: line[index] takes data=mem_rdata, tag=latched tag, valid=1. Go to IDLE.
  - The next cycle is a hit and is counted in hit_count. Total read-miss latency = ack cycle + 1.
- WRITE state:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata held from latch, Stall=1.
  - On mem_ack: if the latched address hits, update data[index]; a miss leaves the cache unchanged (no allocate). Go to WDONE.
- WDONE state:
  - Stall=0 for exactly one cycle; the core retires the store. Go to IDLE unconditionally.
  - The request seen in this cycle is not re-issued.
- mem_req and mem_addr/mem_wdata stay stable from request until the ack cycle inclusive. mem_req drops the cycle after the ack.
- mem_ack outside FILL/WRITE is ignored.
- Address/WriteData changes while Stall=1 are a core protocol violation. The cache uses the latched values only.
- Counters only increment in IDLE on a new read decision. They do not wrap.
- Reset asserted mid-FILL or mid-WRITE:
  - Immediate return to IDLE; mem_req drops asynchronously; all lines invalidated.
  - A late mem_ack after reset is ignored.

Test Plan:
- Reset then MemRead Address=0x05, backing returns 0xA7 with ack 3 cycles after req -> Stall=1 for 4 cycles, mem_addr=0x05, mem_we=0; then ReadData=0xA7, Stall=0; miss_count=1, hit_count=1.
- Repeat the same read immediately -> Stall=0, ReadData=0xA7 same cycle, no mem_req, hit_count=2.
- Conflict: read 0x05 then read 0x09 (same index 1, different tag) -> second is a miss with mem_addr=0x09. Then re-reading 0x05 misses again; miss_count=3.
- Write hit: after 0x05 is cached, MemWrite 0x05 WriteData=0x3C, ack after 2 cycles -> mem_we=1, mem_wdata=0x3C, Stall high until ack, one WDONE cycle with Stall=0. A later read of 0x05 hits with 0x3C.
- Write miss to 0x0E -> backing write issued; subsequent read of 0x0E misses (no allocate). MemRead+MemWrite together -> behaves as write only.
- Reset pulsed during FILL before ack -> mem_req=0 immediately, state IDLE, counters 0. Late ack ignored; next read of the same address misses.
- Counter saturation with CNTW=2 -> four read misses leave miss_count=3.

Source files
------------

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// There is one word per line. Loads that hit return data in the same cycle.
// Read misses and all stores stall the core while the backing memory is accessed.
// Saturating read-hit and read-miss counters are provided for performance inspection.
module dcache_wt #(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned NLINES = 4,
  parameter int unsigned CNTW   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-3:0] Address,
  input  logic [NBITS-1:0] WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [NBITS-1:0] ReadData,
  output logic             Stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-3:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [CNTW-1:0]  hit_count,
  output logic [CNTW-1:0]  miss_count
);

  localparam int unsigned AddrW = NBITS - 2;
  localparam int unsigned IdxW  = $clog2(NLINES);
  localparam int unsigned TagW  = AddrW - IdxW;

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StWdone} state_t;

  state_t               state_q;
  logic [NLINES-1:0]    valid_q;
  logic [TagW-1:0]      tag_q  [NLINES];
  logic [NBITS-1:0]     data_q [NLINES];

  logic [IdxW-1:0]      req_idx, lat_idx;
  logic [TagW-1:0]      req_tag, lat_tag;
  logic                 req_hit, lat_hit;
  logic                 is_write, is_read;

  // The live request is looked up directly.
  // mem_addr doubles as the latched address of the transaction in flight.
  assign req_idx  = Address[IdxW-1:0];
  assign req_tag  = Address[AddrW-1:IdxW];
  assign lat_idx  = mem_addr[IdxW-1:0];
  assign lat_tag  = mem_addr[AddrW-1:IdxW];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit  = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // A simultaneous read and write is treated as a write.
  assign is_write = MemWrite;
  assign is_read  = MemRead && !MemWrite;

  // Combinational stall and load-data return
  always_comb begin
    Stall    = 1'b0;
    ReadData = '0;
    unique case (state_q)
      StIdle: begin
        if (is_write) begin
          Stall = 1'b1;
        end else if (is_read) begin
          if (req_hit) begin
            ReadData = data_q[req_idx];
          end else begin
            Stall = 1'b1;
          end
        end
      end
      StFill, StWrite: Stall = 1'b1;
      StWdone:         Stall = 1'b0;
      default:         Stall = 1'b0;
    endcase
  end

  // Controller FSM with registered backing-memory request outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_write) begin
            state_q   <= StWrite;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= Address;
            mem_wdata <= WriteData;
          end else if (is_read && !req_hit) begin
            state_q  <= StFill;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= Address;
          end
        end
        StFill: begin
          if (mem_ack) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
          end
        end
        StWrite: begin
          if (mem_ack) begin
            state_q <= StWdone;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        // One stall-free cycle lets the core retire the store.
        // The store is not re-issued in this cycle.
        StWdone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line storage: fill on read ack; update on write ack only if the line is present
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NLINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (state_q == StFill && mem_ack) begin
      valid_q[lat_idx] <= 1'b1;
      tag_q[lat_idx]   <= lat_tag;
      data_q[lat_idx]  <= mem_rdata;
    end else if (state_q == StWrite && mem_ack && lat_hit) begin
      data_q[lat_idx] <= mem_wdata;
    end
  end

  // Saturating counters.
  // They count one event per read decision taken in the idle state.
  // The post-fill retry is counted as a hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == StIdle && is_read) begin
      if (req_hit) begin
        if (hit_count != '1) hit_count <= hit_count + CNTW'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt.
// The bench runs a hand-computed vector table, then a reset-during-fill sequence.
// It finishes with random traffic checked against a line-array reference model.
module tb_dcache_wt;

  localparam int NL = 4;

  logic       clock;
  logic       reset;
  logic [5:0] Address;
  logic [7:0] WriteData;
  logic       MemRead, MemWrite;
  logic [7:0] ReadData;
  logic       Stall;
  logic       mem_req, mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_ack;
  logic [7:0] hit_count, miss_count;

  // Second instance with 2-bit counters shares every input.
  // Its outputs must track the main instance except for counter saturation.
  logic [7:0] s_ReadData, s_mem_wdata;
  logic       s_Stall, s_mem_req, s_mem_we;
  logic [5:0] s_mem_addr;
  logic [1:0] s_hit_count, s_miss_count;

  dcache_wt #(.NBITS(8), .NLINES(4), .CNTW(8)) u_dut (
    .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .Stall(Stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  dcache_wt #(.NBITS(8), .NLINES(4), .CNTW(2)) u_sat (
    .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(s_ReadData), .Stall(s_Stall),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(s_hit_count),
    .miss_count(s_miss_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    if (i == 5) return 8'hA7;
    if (i == 9) return 8'h5B;
    return 8'((i * 29 + 7));
  endfunction

  // Backing memory responder: acks ack_lat cycles after the request first appears
  logic [7:0] backing [64];
  int         ack_lat = 1;
  bit         auto_ack = 1'b1;
  int         late_seq = 0;
  initial begin
    int req_cnt;
    int late_done;
    for (int i = 0; i < 64; i++) backing[i] = init_val(i);
    mem_ack = 1'b0; mem_rdata = '0; req_cnt = 0; late_done = 0;
    forever begin
      @(posedge clock); #1;
      mem_ack = 1'b0;
      if (late_seq != late_done) begin
        late_done = late_seq;
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
      end else if (auto_ack && mem_req) begin
        req_cnt++;
        if (req_cnt >= ack_lat) begin
          req_cnt = 0;
          mem_ack = 1'b1;
          if (mem_we) backing[mem_addr] = mem_wdata;
          else mem_rdata = backing[mem_addr];
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // Reference model: per-line valid/tag/data, backing image, counters
  bit         m_valid [NL];
  int         m_tag   [NL];
  logic [7:0] m_data  [NL];
  logic [7:0] ref_mem [64];
  int         m_hit, m_miss;

  function automatic void model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_hit = 0; m_miss = 0;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  function automatic bit model_hit(input int a);
    return m_valid[a % NL] && m_tag[a % NL] == a / NL;
  endfunction

  // Returns expected stall cycles, expected load data
  function automatic void model_access(input bit rd, input bit wr, input int a,
                                       input logic [7:0] wd, input int lat,
                                       output int stalls, output logic [7:0] rdata);
    rdata = '0;
    if (wr) begin
      if (model_hit(a)) m_data[a % NL] = wd;
      ref_mem[a] = wd;
      stalls = lat + 1;
    end else if (rd) begin
      if (model_hit(a)) begin
        stalls = 0;
      end else begin
        m_miss = sat(m_miss, 255);
        m_valid[a % NL] = 1'b1;
        m_tag[a % NL] = a / NL;
        m_data[a % NL] = ref_mem[a];
        stalls = lat + 1;
      end
      m_hit = sat(m_hit, 255);
      rdata = m_data[a % NL];
    end else begin
      stalls = 0;
    end
  endfunction

  // Runs one core request to completion and compares everything observed
  task automatic run_txn(input string nm, input bit rd, input bit wr, input logic [5:0] a,
                         input logic [7:0] wd, input int lat, input int exp_stalls,
                         input logic [7:0] exp_rdata, input int exp_hit, input int exp_miss);
    int         stalls;
    bit         done, req_seen, we_s, req_end;
    logic [5:0] addr_s;
    logic [7:0] wdata_s, rdata;
    stalls = 0; done = 0; req_seen = 0; we_s = 0; addr_s = '0; wdata_s = '0;
    rdata = '0; req_end = 0;
    @(posedge clock); #1;
    ack_lat = lat;
    MemRead = rd; MemWrite = wr; Address = a; WriteData = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (mem_req && !req_seen) begin
        req_seen = 1; we_s = mem_we; addr_s = mem_addr; wdata_s = mem_wdata;
      end
      if (!Stall) begin
        done = 1; rdata = ReadData; req_end = mem_req;
      end else begin
        stalls++;
      end
    end
    check({nm, " done"}, done, 1);
    check({nm, " stalls"}, stalls, exp_stalls);
    check({nm, " req"}, req_seen, exp_stalls > 0);
    check({nm, " req drop"}, req_end, 0);
    if (req_seen) begin
      check({nm, " we"}, we_s, wr);
      check({nm, " addr"}, addr_s, a);
      if (wr) check({nm, " wdata"}, wdata_s, wd);
    end
    if (rd && !wr) check({nm, " rdata"}, rdata, exp_rdata);
    @(posedge clock); #1;
    MemRead = 0; MemWrite = 0;
    @(negedge clock);
    check({nm, " hits"}, hit_count, exp_hit);
    check({nm, " misses"}, miss_count, exp_miss);
    check({nm, " sat hits"}, s_hit_count, exp_hit > 3 ? 3 : exp_hit);
    check({nm, " sat misses"}, s_miss_count, exp_miss > 3 ? 3 : exp_miss);
  endtask

  typedef struct {
    bit         rd;
    bit         wr;
    logic [5:0] addr;
    logic [7:0] wd;
    int         lat;
    int         exp_stalls;
    logic [7:0] exp_rdata;
    int         exp_hit;
    int         exp_miss;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int         es;
    logic [7:0] ed;
    vecs[0] = '{1, 0, 6'h05, 8'h00, 3, 4, 8'hA7, 1, 1};  // cold miss, ack 3 cycles in
    vecs[1] = '{1, 0, 6'h05, 8'h00, 3, 0, 8'hA7, 2, 1};  // immediate hit
    vecs[2] = '{1, 0, 6'h09, 8'h00, 2, 3, 8'h5B, 3, 2};  // conflict on index 1
    vecs[3] = '{1, 0, 6'h05, 8'h00, 1, 2, 8'hA7, 4, 3};  // evicted, misses again
    vecs[4] = '{0, 1, 6'h05, 8'h3C, 2, 3, 8'h00, 4, 3};  // write hit
    vecs[5] = '{1, 0, 6'h05, 8'h00, 1, 0, 8'h3C, 5, 3};  // sees written data
    vecs[6] = '{0, 1, 6'h0E, 8'h77, 1, 2, 8'h00, 5, 3};  // write miss, no allocate
    vecs[7] = '{1, 0, 6'h0E, 8'h00, 2, 3, 8'h77, 6, 4};  // still a miss
    vecs[8] = '{1, 1, 6'h05, 8'h99, 1, 2, 8'h00, 6, 4};  // read+write acts as write
    vecs[9] = '{1, 0, 6'h05, 8'h00, 1, 0, 8'h99, 7, 4};

    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    model_clear();
    reset = 1'b1; MemRead = 0; MemWrite = 0; Address = '0; WriteData = '0;
    repeat (3) @(negedge clock);
    check("reset Stall", Stall, 0);
    check("reset ReadData", ReadData, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset hits", hit_count, 0);
    check("reset misses", miss_count, 0);
    reset = 1'b0;

    // Directed table; the model is advanced too so its state stays in step
    for (int i = 0; i < 10; i++) begin
      model_access(vecs[i].rd, vecs[i].wr, int'(vecs[i].addr), vecs[i].wd, vecs[i].lat, es, ed);
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
              vecs[i].lat, vecs[i].exp_stalls, vecs[i].exp_rdata, vecs[i].exp_hit,
              vecs[i].exp_miss);
    end

    // Reset asserted mid-fill, then a stray ack afterwards
    auto_ack = 1'b0;
    @(posedge clock); #1;
    MemRead = 1; Address = 6'h05;  // still cached as 0x99 - need a miss: use 0x01
    Address = 6'h01;
    @(negedge clock);
    check("rst pre stall", Stall, 1);
    @(negedge clock);
    check("rst fill req", mem_req, 1);
    #1 reset = 1'b1;
    #1;
    check("rst async req", mem_req, 0);
    check("rst hits", hit_count, 0);
    check("rst misses", miss_count, 0);
    MemRead = 0;
    @(negedge clock);
    reset = 1'b0;
    late_seq = late_seq + 1;
    repeat (2) @(negedge clock);
    check("late ack req", mem_req, 0);
    check("late ack stall", Stall, 0);
    model_clear();
    auto_ack = 1'b1;
    run_txn("post reset", 1, 0, 6'h05, 8'h00, 2, 3, ref_mem[5], 1, 1);
    model_access(1, 0, 5, 8'h00, 2, es, ed);

    // Random traffic against the model
    for (int n = 0; n < 200; n++) begin
      int         a, lat, op;
      bit         rd, wr;
      logic [7:0] wd;
      a   = $urandom_range(0, 15);
      lat = $urandom_range(1, 4);
      op  = $urandom_range(0, 9);
      wd  = 8'($urandom);
      rd  = (op < 6) || (op == 9);
      wr  = (op >= 6);
      model_access(rd, wr, a, wd, lat, es, ed);
      run_txn($sformatf("rnd%0d", n), rd, wr, 6'(a), wd, lat, es, ed, m_hit, m_miss);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
